// File: rtl/result_demux_pkg.sv
// Shared constants and helpers for the result demultiplexer and its channel FIFOs.
package result_demux_pkg;

   localparam int FIFO_DEPTH = 2;
   localparam int DROP_W     = 16;

   function automatic int chan_off(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/result_demux_if.sv
// Bus between the result producer and the per-channel consumers of result_demux.
interface result_demux_if
   import result_demux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEL_W = 2
);
   localparam int N = 1 << SEL_W;

   logic               flush;
   logic               in_valid;
   logic [SEL_W-1:0]   in_sel;
   logic [WIDTH-1:0]   in_data;
   logic               in_ready;
   logic [N-1:0]       out_valid;
   logic [N*WIDTH-1:0] out_data;
   logic [N-1:0]       out_ready;
   logic [N*2-1:0]     count;
   logic [DROP_W-1:0]  drop_cnt;

   modport master (
      output flush, in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, drop_cnt
   );

   modport slave (
      input  flush, in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, count, drop_cnt
   );
endinterface

// File: rtl/result_chan_fifo.sv
// Two-entry channel FIFO with 1-bit pointers; flush empties it without touching storage.
module result_chan_fifo
   import result_demux_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);
   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   // A pop request on an empty channel is ignored.
   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && (r_count != 2'(FIFO_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/result_demux.sv
// Routes one result stream to 2^SEL_W channel FIFOs and counts flush-discarded entries.
module result_demux
   import result_demux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEL_W = 2
) (
   input logic           clk,
   input logic           rst,
   result_demux_if.slave bus
);
   localparam int N     = 1 << SEL_W;
   localparam int SUM_W = SEL_W + 2;

   logic [1:0]        w_count [N];
   logic              w_valid [N];
   logic [WIDTH-1:0]  w_data  [N];
   logic [N-1:0]      w_push_en;
   logic              w_in_ready;
   logic [SUM_W-1:0]  w_flush_sum;
   logic [DROP_W-1:0] r_drop_cnt;

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [SUM_W-1:0]  b);
      logic [DROP_W:0] s;
      s = {1'b0, a} + (DROP_W + 1)'(b);
      return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
   endfunction

   // Depends only on registered occupancy, never on out_ready.
   assign w_in_ready = !bus.flush && (w_count[bus.in_sel] != 2'(FIFO_DEPTH));
   assign bus.in_ready = w_in_ready;

   always_comb begin
      w_push_en = '0;
      if (bus.in_valid && w_in_ready) w_push_en[bus.in_sel] = 1'b1;
   end

   for (genvar g = 0; g < N; g++) begin : g_chan
      localparam int OFF = chan_off(g, WIDTH);

      result_chan_fifo #(.WIDTH(WIDTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_flush (bus.flush),
         .i_push  (w_push_en[g]),
         .i_data  (bus.in_data),
         .i_pop   (bus.out_ready[g]),
         .o_valid (w_valid[g]),
         .o_data  (w_data[g]),
         .o_count (w_count[g])
      );

      assign bus.out_valid[g]            = w_valid[g];
      assign bus.out_data[OFF +: WIDTH]  = w_data[g];
      assign bus.count[2*g +: 2]         = w_count[g];
   end

   always_comb begin
      w_flush_sum = '0;
      for (int i = 0; i < N; i++) w_flush_sum = w_flush_sum + SUM_W'(w_count[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (bus.flush) begin
         r_drop_cnt <= sat_add(r_drop_cnt, w_flush_sum);
      end
   end

   assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: doc/result_demux.md
Name: result_demux

Overview:
- 1-to-4 result demultiplexer for the dynamic pipeline; the distributing counterpart of the select-one-of-N source muxes.
- Takes one result stream from a functional unit and routes each word, by a destination select, to one of 2^SEL_W consumer channels (reservation stations / write-back buffers).
- Each channel has a 2-entry FIFO with valid/ready handshake, so a stalled consumer never blocks traffic to the other channels.

Parameters:
- WIDTH, 32, data word width.
- SEL_W, 2, destination select width; N = 2^SEL_W channels.
- DEPTH, 2, entries per channel FIFO; fixed at 2, pointers are 1 bit.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all channel FIFOs (branch mispredict).
- in_valid  in  1  input word present.
- in_sel  in  SEL_W  destination channel index.
- in_data  in  WIDTH  input word.
- in_ready  out  1  input accepted this cycle when in_valid && in_ready.
- out_valid  out  N  per-channel head valid.
- out_data  out  N*WIDTH  per-channel head word; channel i at bits [i*WIDTH +: WIDTH].
- out_ready  in  N  per-channel consumer pop.
- count  out  N*2  per-channel occupancy 0..2; channel i at [2i +: 2].
- drop_cnt  out  16  saturating count of flush-discarded entries.

Behaviour:
- Reset (async, rst=1): all counts 0, read/write pointers 0, out_valid all 0, out_data all 0, drop_cnt 0. Storage is cleared as well, so no X values appear on out_data.
- in_ready = !flush && (count[in_sel] != 2). It is combinational on in_sel, flush and registered count only. There is no combinational path from out_ready to in_ready: a full channel cannot accept in the same cycle it pops.
- Push: in_valid && in_ready writes in_data to channel in_sel at wptr, then wptr toggles and count increments. Exactly one channel is written per cycle.
- Pop: out_valid[i] && out_ready[i] advances rptr[i] and decrements count[i]. All channels may pop in the same cycle.
- Push and pop on the same channel in the same cycle (count 1): count stays 1, head advances to the new word. Latency is one cycle from accept to out_valid.
- Push and pop on the same channel at count 0: not possible, since out_valid=0. The word appears next cycle (no bypass).
- out_valid[i] = (count[i] != 0). out_data[i] = storage[rptr[i]], driven from registers.
- out_ready[i] while out_valid[i]=0 is ignored.
- Pointer wrap: 1-bit pointers wrap naturally between 1 and 0. Ordering within a channel is FIFO. There is no ordering guarantee across channels.
- in_valid with an in_sel whose channel is full: the input is held (in_ready=0). Other selects are unaffected on later cycles.
- flush=1:
  - All counts and pointers go to 0 at the next edge, and in_ready=0 that cycle.
  - Pops in the flush cycle are discarded.
  - drop_cnt += sum of count[i] before the flush, saturating at 16'hFFFF.
- Flush has priority over simultaneous push and pop.
- Reset mid-operation clears everything immediately, independent of clk. drop_cnt is not incremented by reset.
- in_data is don't-care when in_valid=0.

Decomposition:
- Shared package (or header) holds:
  - the constant for FIFO depth 2;
  - the drop counter width 16;
  - a function for channel slice offset (i*WIDTH).
- One natural sub-module: result_chan_fifo, a 2-entry FIFO with push, pop, flush, count and head outputs. It is instantiated N times in a generate loop.
- The top level contains only:
  - the select decode (one-hot push enables);
  - the in_ready mux;
  - the drop counter adder/saturation.

Test Plan:
- Reset then idle: out_valid=4'b0000, count all 0, in_ready=1 for every in_sel, drop_cnt=0.
- Send 0x11 (sel 2) then 0x22 (sel 0), with out_ready=0 → out_valid=4'b0101, ch2 head 0x11, ch0 head 0x22.
- Stall ch1:
  - Push 0xA, 0xB, 0xC to sel 1 with out_ready[1]=0 → the first two are accepted and count[1]=2.
  - The third stalls with in_ready=0; a sel 3 push of 0xD in the following cycle is accepted.
- Release ch1: raise out_ready[1] → data 0xA, 0xB, 0xC drains in order. in_ready for sel 1 returns 1 one cycle after the first pop.
- Same-cycle push+pop on ch0 at count 1 → count stays 1, head changes from the old word to the new word next cycle.
- Fill ch0=2, ch3=1, then pulse flush with simultaneous in_valid → all counts 0, in_ready=0 during flush, drop_cnt=3. Assert async rst mid-stream → outputs zero before the next clk edge.
